// File: rtl/exp6_uc_pkg.sv
// Purpose: shared state type and state codes for the Experiment 6 control unit.
// Latency: none (constants and pure helper functions only).
// Backpressure: not applicable.
package exp6_uc_pkg;

  // 4-bit state type; these codes also appear on db_estado for the 7-segment debug display.
  typedef enum logic [3:0] {
    S_IDLE             = 4'h0,
    S_PREPARACAO       = 4'h1,
    S_INICIO           = 4'h2,
    S_ESPERA           = 4'h3,
    S_REGISTRA         = 4'h4,
    S_ATUALIZA_MEMORIA = 4'h5,
    S_COMPARACAO       = 4'h6,
    S_PROXIMA_JOGADA   = 4'h7,
    S_ULTIMA_JOGADA    = 4'h8,
    S_PROXIMA_RODADA   = 4'h9,
    S_FIM_A            = 4'hA,
    S_FIM_T            = 4'hD,
    S_FIM_E            = 4'hE
  } estado_t;

  localparam int ESTADO_W = 4;

  // True for any end-of-game state; the game is over and waits for a restart.
  function automatic logic is_fim(input estado_t e);
    return (e == S_FIM_A) || (e == S_FIM_T) || (e == S_FIM_E);
  endfunction

endpackage

// File: rtl/exp6_unidade_controle.sv
// Purpose: Moore FSM driving every exp6_fluxo_dados control strobe; optional play timeout via UC_TIMEOUT_EN.
// Latency: outputs decode the state register only, so they change one edge after the inputs that cause them.
// Backpressure: none; inputs are sampled every cycle and the datapath is assumed always ready.
import exp6_uc_pkg::*;

module exp6_unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimL,
  input  logic       timeout,
  output logic       zeraCR,
  output logic       zeraE,
  output logic       contaCR,
  output logic       contaE,
  output logic       limpaRC,
  output logic       registraRC,
  output logic       zeraLeds,
  output logic       registraLeds,
  output logic       led_selector,
  output logic       contaT,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t proximo;

`ifndef UC_TIMEOUT_EN
  // Without the timer the timeout flag has no consumer.
  logic unused_timeout;
  assign unused_timeout = timeout;
`endif

  // State register; reset wins over every input, in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= S_IDLE;
    end else begin
      estado <= proximo;
    end
  end

  // Next-state logic; status flags only matter in the states that test them.
  always_comb begin
    proximo = S_IDLE;
    case (estado)
      S_IDLE:             proximo = jogar ? S_PREPARACAO : S_IDLE;
      S_PREPARACAO:       proximo = S_INICIO;
      S_INICIO:           proximo = S_ESPERA;
      S_ESPERA: begin
`ifdef UC_TIMEOUT_EN
        // Timeout beats a play arriving in the same cycle.
        if (timeout) begin
          proximo = S_FIM_T;
        end else if (jogada_feita) begin
          proximo = S_REGISTRA;
        end else begin
          proximo = S_ESPERA;
        end
`else
        proximo = jogada_feita ? S_REGISTRA : S_ESPERA;
`endif
      end
      S_REGISTRA:         proximo = S_ATUALIZA_MEMORIA;
      S_ATUALIZA_MEMORIA: proximo = S_COMPARACAO;
      S_COMPARACAO: begin
        if (!jogada_correta) begin
          proximo = S_FIM_E;
        end else if (enderecoIgualRodada) begin
          proximo = S_ULTIMA_JOGADA;
        end else begin
          proximo = S_PROXIMA_JOGADA;
        end
      end
      S_PROXIMA_JOGADA:   proximo = S_ESPERA;
      S_ULTIMA_JOGADA:    proximo = fimL ? S_FIM_A : S_PROXIMA_RODADA;
      S_PROXIMA_RODADA:   proximo = S_INICIO;
      S_FIM_A:            proximo = jogar ? S_PREPARACAO : S_FIM_A;
`ifdef UC_TIMEOUT_EN
      S_FIM_T:            proximo = jogar ? S_PREPARACAO : S_FIM_T;
`endif
      S_FIM_E:            proximo = jogar ? S_PREPARACAO : S_FIM_E;
      // Unused codes (and fim_T when the timer is absent) recover to idle.
      default:            proximo = S_IDLE;
    endcase
  end

  // Moore output decode; no input reaches an output combinationally.
  always_comb begin
    zeraCR       = 1'b0;
    zeraE        = 1'b0;
    contaCR      = 1'b0;
    contaE       = 1'b0;
    limpaRC      = 1'b0;
    registraRC   = 1'b0;
    zeraLeds     = 1'b0;
    registraLeds = 1'b0;
    led_selector = 1'b0;
    contaT       = 1'b0;
    pronto       = 1'b0;
    ganhou       = 1'b0;
    perdeu       = 1'b0;
    case (estado)
      S_IDLE: begin
        zeraCR   = 1'b1;
        zeraE    = 1'b1;
        limpaRC  = 1'b1;
        zeraLeds = 1'b1;
      end
      S_PREPARACAO: begin
        zeraCR       = 1'b1;
        zeraE        = 1'b1;
        limpaRC      = 1'b1;
        zeraLeds     = 1'b1;
        led_selector = 1'b1;
      end
      S_INICIO: begin
        zeraE        = 1'b1;
        registraLeds = 1'b1;
        led_selector = 1'b1;
      end
      S_ESPERA: begin
`ifdef UC_TIMEOUT_EN
        contaT = 1'b1;
`endif
      end
      S_REGISTRA: begin
        registraRC   = 1'b1;
        registraLeds = 1'b1;
      end
      S_PROXIMA_JOGADA: contaE = 1'b1;
      S_PROXIMA_RODADA: begin
        contaCR      = 1'b1;
        led_selector = 1'b1;
      end
      S_FIM_A: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
`ifdef UC_TIMEOUT_EN
      S_FIM_T: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
`endif
      S_FIM_E: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      default: begin
        pronto = 1'b0;
      end
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// Purpose: self-checking bench for exp6_unidade_controle against a game-level reference model.
// Latency: model advances one state per rising edge; outputs sampled 1 ns after the edge.
// Backpressure: not applicable.
`timescale 1ns/1ps
import exp6_uc_pkg::*;

module tb_exp6_unidade_controle;

  logic       clock = 1'b0;
  logic       reset, jogar, jogada_feita, jogada_correta, enderecoIgualRodada, fimL, timeout;
  logic       zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC, zeraLeds, registraLeds;
  logic       led_selector, contaT, pronto, ganhou, perdeu;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int m_state = 0;   // reference model state, as the display code

`ifdef UC_TIMEOUT_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  always #10 clock = ~clock;

  exp6_unidade_controle dut (
    .clock(clock), .reset(reset), .jogar(jogar), .jogada_feita(jogada_feita),
    .jogada_correta(jogada_correta), .enderecoIgualRodada(enderecoIgualRodada),
    .fimL(fimL), .timeout(timeout),
    .zeraCR(zeraCR), .zeraE(zeraE), .contaCR(contaCR), .contaE(contaE),
    .limpaRC(limpaRC), .registraRC(registraRC), .zeraLeds(zeraLeds),
    .registraLeds(registraLeds), .led_selector(led_selector), .contaT(contaT),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .db_estado(db_estado)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Game rules: where the game goes after one clock edge with the given inputs.
  function automatic int model_next(int s, bit rst, bit jg, bit jf, bit jc, bit eir, bit fl, bit to);
    if (rst) return 0;
    if (s == 0) return jg ? 1 : 0;
    if (s == 1) return 2;
    if (s == 2) return 3;
    if (s == 3) begin
      if (TIMER && to) return 'hD;
      return jf ? 4 : 3;
    end
    if (s == 4) return 5;
    if (s == 5) return 6;
    if (s == 6) return !jc ? 'hE : (eir ? 8 : 7);
    if (s == 7) return 3;
    if (s == 8) return fl ? 'hA : 9;
    if (s == 9) return 2;
    if (s == 'hA || s == 'hE || (TIMER && s == 'hD)) return jg ? 1 : s;
    return 0;
  endfunction

  // Which strobes each state raises, listed per strobe.
  function automatic logic [12:0] model_outs(int s);
    logic [12:0] o;
    o[12] = s inside {0, 1};               // zeraCR
    o[11] = s inside {0, 1, 2};            // zeraE
    o[10] = (s == 9);                      // contaCR
    o[9]  = (s == 7);                      // contaE
    o[8]  = s inside {0, 1};               // limpaRC
    o[7]  = (s == 4);                      // registraRC
    o[6]  = s inside {0, 1};               // zeraLeds
    o[5]  = s inside {2, 4};               // registraLeds
    o[4]  = s inside {1, 2, 9};            // led_selector
    o[3]  = TIMER && (s == 3);             // contaT
    o[2]  = s inside {'hA, 'hD, 'hE};      // pronto
    o[1]  = (s == 'hA);                    // ganhou
    o[0]  = s inside {'hD, 'hE};           // perdeu
    return o;
  endfunction

  // Apply inputs, take one edge, advance the model and compare all outputs.
  task automatic step(input bit rst, input bit jg, input bit jf, input bit jc,
                      input bit eir, input bit fl, input bit to);
    reset = rst; jogar = jg; jogada_feita = jf; jogada_correta = jc;
    enderecoIgualRodada = eir; fimL = fl; timeout = to;
    @(posedge clock);
    m_state = model_next(m_state, rst, jg, jf, jc, eir, fl, to);
    #1;
    check("db_estado", {28'd0, db_estado}, m_state);
    check("strobes", {19'd0, zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC, zeraLeds,
                      registraLeds, led_selector, contaT, pronto, ganhou, perdeu},
          {19'd0, model_outs(m_state)});
  endtask

  task automatic idle_step();
    step(0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    reset = 1; jogar = 0; jogada_feita = 0; jogada_correta = 0;
    enderecoIgualRodada = 0; fimL = 0; timeout = 0;
    @(negedge clock);

    // Reset for two cycles
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rst_estado", db_estado, 0);
    check("rst_zeras", {zeraCR, zeraE, limpaRC, zeraLeds, pronto}, 5'b11110);

    // Start: 1, 2, 3
    step(0, 1, 0, 0, 0, 0, 0);
    check("start1", db_estado, 1);
    check("led_sel1", led_selector, 1);
    idle_step();
    check("start2", db_estado, 2);
    check("led_sel2", led_selector, 1);
    idle_step();
    check("start3", db_estado, 3);
    check("contaT3", contaT, TIMER);

    // Correct last play of round 1: 4,5,6,8,9,2
    step(0, 0, 1, 1, 1, 0, 0);
    check("r1_4", db_estado, 4);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    check("r1_6", db_estado, 6);
    step(0, 0, 0, 1, 1, 0, 0);
    check("r1_8", db_estado, 8);
    check("contaCR8", contaCR, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    check("r1_9", db_estado, 9);
    check("contaCR9", contaCR, 1);
    idle_step();
    check("r1_2", db_estado, 2);
    check("contaCR2", contaCR, 0);

    // Wrong play -> fim_E, hold 50 cycles, restart
    idle_step();
    step(0, 0, 1, 0, 0, 0, 0);
    idle_step(); idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
    check("erro_E", db_estado, 'hE);
    check("erro_flags", {perdeu, pronto, ganhou}, 3'b110);
    for (int i = 0; i < 50; i++) step(0, 0, $urandom_range(0, 1), 0, 0, 1, 1);
    check("erro_hold", db_estado, 'hE);
    step(0, 1, 0, 0, 0, 0, 0);
    check("erro_restart", db_estado, 1);

    // Timeout vs play in the same cycle
    idle_step(); idle_step();
    step(0, 0, 1, 1, 0, 0, 1);
    check("timeout_prio", db_estado, TIMER ? 'hD : 4);

    // Win
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    idle_step(); idle_step();
    step(0, 0, 1, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    check("win_A", db_estado, 'hA);
    check("win_ganhou", ganhou, 1);

    // Mid-game reset from atualiza_memoria
    step(0, 1, 0, 0, 0, 0, 0);
    idle_step(); idle_step();
    step(0, 0, 1, 1, 0, 0, 0);
    idle_step();
    check("mid_5", db_estado, 5);
    step(1, 1, 1, 1, 1, 1, 1);
    check("mid_rst", db_estado, 0);

    // Randomized play against the model
    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
